// File: rtl/c3lib_ckg_mgr_pkg.sv
// Shared types and elaboration helpers for the N-channel clock-gate manager.
package c3lib_ckg_mgr_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } ckg_st_t;

  localparam int MAX_CH = 32;

  // The wake counter must be able to hold WAKE_CYC-1.
  function automatic bit wake_cyc_ok(input int wake_cyc, input int cnt_w);
    longint lim;
    lim = longint'(1) << cnt_w;
    return (wake_cyc >= 1) && (longint'(wake_cyc) < lim);
  endfunction

endpackage

// File: rtl/c3lib_ckg_lvt_8x.sv
// Latch-based clock gating cell: enable captured while clk is low, te forces transparency.
module c3lib_ckg_lvt_8x (
  input  logic tst_en,
  input  logic clk_en,
  input  logic clk,
  output logic gated_clk
);

  logic r_en_lat;

  always_latch begin
    if (!clk) r_en_lat <= clk_en | tst_en;
  end

  assign gated_clk = clk & r_en_lat;

endmodule

// File: rtl/c3lib_ckg_mgr_ch.sv
// One gated channel: OFF/WAKE/ON/IDLE controller, wake/idle counter and its gating cell.
module c3lib_ckg_mgr_ch
  import c3lib_ckg_mgr_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tst_en,
  input  logic             i_req,
  input  logic             i_busy,
  input  logic             i_force_on,
  input  logic [CNT_W-1:0] i_idle_cyc,
  output logic             o_ack,
  output logic             o_clk_en,
  output logic             o_gated_clk,
  output logic             o_is_off
);

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

  ckg_st_t          r_st;
  ckg_st_t          w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_wake;
  logic             w_hold;
  logic             r_ack;
  logic             r_clk_en;

  assign w_wake    = i_req | i_force_on;
  assign w_hold    = i_req | i_busy | i_force_on;
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_cnt_sat = w_cnt_inc[CNT_W] ? '1 : w_cnt_inc[CNT_W-1:0];

  // Activity in IDLE beats the timeout; a zero timeout parks the channel in ON.
  always_comb begin
    w_nxt     = r_st;
    w_cnt_nxt = r_cnt;
    unique case (r_st)
      ST_OFF: begin
        if (w_wake) begin
          w_nxt     = ST_WAKE;
          w_cnt_nxt = '0;
        end
      end
      ST_WAKE: begin
        if (r_cnt == WAKE_LAST) w_nxt = ST_ON;
        else                    w_cnt_nxt = w_cnt_sat;
      end
      ST_ON: begin
        if (!w_hold && (i_idle_cyc != '0)) begin
          w_nxt     = ST_IDLE;
          w_cnt_nxt = '0;
        end
      end
      ST_IDLE: begin
        if (w_hold || (i_idle_cyc == '0))         w_nxt = ST_ON;
        else if (w_cnt_inc >= {1'b0, i_idle_cyc}) w_nxt = ST_OFF;
        else                                      w_cnt_nxt = w_cnt_sat;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st     <= ST_OFF;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_clk_en <= 1'b0;
    end else begin
      r_st     <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ack    <= (w_nxt == ST_ON) || (w_nxt == ST_IDLE);
      r_clk_en <= (w_nxt != ST_OFF);
    end
  end

  assign o_ack    = r_ack;
  assign o_clk_en = r_clk_en;
  assign o_is_off = (r_st == ST_OFF);

  c3lib_ckg_lvt_8x u_ckg (
    .tst_en    (tst_en),
    .clk_en    (r_clk_en),
    .clk       (clk),
    .gated_clk (o_gated_clk)
  );

endmodule

// File: rtl/c3lib_ckg_mgr_nch.sv
// N-channel clock-gate manager: independent per-channel controllers plus a registered all-off flag.
module c3lib_ckg_mgr_nch
  import c3lib_ckg_mgr_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tst_en,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_busy,
  input  logic [NUM_CH-1:0] cfg_force_on,
  input  logic [CNT_W-1:0]  cfg_idle_cyc,
  output logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] ch_clk_en,
  output logic [NUM_CH-1:0] gated_clk,
  output logic              all_off
);

  if (!wake_cyc_ok(WAKE_CYC, CNT_W) || (NUM_CH < 1) || (NUM_CH > MAX_CH)) begin : g_bad_param
    $error("c3lib_ckg_mgr_nch: illegal NUM_CH=%0d or WAKE_CYC=%0d for CNT_W=%0d",
           NUM_CH, WAKE_CYC, CNT_W);
  end

  logic [NUM_CH-1:0] w_is_off;
  logic              r_all_off;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    c3lib_ckg_mgr_ch #(
      .CNT_W    (CNT_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tst_en      (tst_en),
      .i_req       (ch_req[g]),
      .i_busy      (ch_busy[g]),
      .i_force_on  (cfg_force_on[g]),
      .i_idle_cyc  (cfg_idle_cyc),
      .o_ack       (ch_ack[g]),
      .o_clk_en    (ch_clk_en[g]),
      .o_gated_clk (gated_clk[g]),
      .o_is_off    (w_is_off[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_all_off <= 1'b1;
    else        r_all_off <= &w_is_off;
  end

  assign all_off = r_all_off;

endmodule

// File: tb/tb_c3lib_ckg_mgr_nch.sv
// Bench for the clock-gate manager: vector table, hand sequences and randomized model checks.
module tb_c3lib_ckg_mgr_nch;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int WC  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tst_en;
  logic [NCH-1:0] ch_req;
  logic [NCH-1:0] ch_busy;
  logic [NCH-1:0] cfg_force_on;
  logic [CW-1:0]  cfg_idle_cyc;
  logic [NCH-1:0] ch_ack;
  logic [NCH-1:0] ch_clk_en;
  logic [NCH-1:0] gated_clk;
  logic           all_off;

  c3lib_ckg_mgr_nch #(.NUM_CH(NCH), .CNT_W(CW), .WAKE_CYC(WC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tst_en       (tst_en),
    .ch_req       (ch_req),
    .ch_busy      (ch_busy),
    .cfg_force_on (cfg_force_on),
    .cfg_idle_cyc (cfg_idle_cyc),
    .ch_ack       (ch_ack),
    .ch_clk_en    (ch_clk_en),
    .gated_clk    (gated_clk),
    .all_off      (all_off)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel is either dark, counting down its wake delay,
  // or lit; a lit channel ages while quiet and goes dark once the age reaches the timeout.
  logic [NCH-1:0] m_en;
  logic [NCH-1:0] m_ack;
  logic           m_all_off;
  int             m_wake_left [NCH];
  int             m_age       [NCH];

  function automatic void model_edge();
    logic was_all_dark;
    logic wake, quiet;
    was_all_dark = (m_en == '0);
    if (!rst_n) begin
      m_en = '0; m_ack = '0; m_all_off = 1'b1;
      for (int i = 0; i < NCH; i++) begin m_wake_left[i] = 0; m_age[i] = -1; end
      return;
    end
    m_all_off = was_all_dark;
    for (int i = 0; i < NCH; i++) begin
      wake  = ch_req[i] | cfg_force_on[i];
      quiet = !(ch_req[i] | ch_busy[i] | cfg_force_on[i]);
      if (!m_en[i]) begin
        if (wake) begin m_en[i] = 1'b1; m_wake_left[i] = WC; end
      end else if (m_wake_left[i] > 0) begin
        m_wake_left[i]--;
        if (m_wake_left[i] == 0) m_ack[i] = 1'b1;
      end else if (m_age[i] < 0) begin
        if (quiet && cfg_idle_cyc != 0) m_age[i] = 0;
      end else if (!quiet || cfg_idle_cyc == 0) begin
        m_age[i] = -1;
      end else if (m_age[i] + 1 >= int'(cfg_idle_cyc)) begin
        m_en[i] = 1'b0; m_ack[i] = 1'b0; m_age[i] = -1;
      end else begin
        m_age[i] = (m_age[i] + 1 > 255) ? 255 : m_age[i] + 1;
      end
    end
  endfunction

  // Inputs are stable here, so the model sees exactly what the DUT samples at the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_clk_en"}, 32'(ch_clk_en), 32'(m_en));
    chk({tag, "_ack"},    32'(ch_ack),    32'(m_ack));
    chk({tag, "_all_off"}, 32'(all_off),  32'(m_all_off));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ch_req = '0; ch_busy = '0; cfg_force_on = '0; tst_en = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Bring channel 0 from OFF to ON and one quiet edge into IDLE.
  task automatic wake_ch0_to_idle();
    ch_req = 4'h1; step();
    ch_req = 4'h0; step();
    step();
    chk("seq_ch0_on_ack", 32'(ch_ack[0]), 32'd1);
    step();
  endtask

  typedef struct {
    logic           rst_n;
    logic [NCH-1:0] req;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] frc;
    logic [CW-1:0]  idle;
    logic [NCH-1:0] en;
    logic [NCH-1:0] ack;
    logic           all_off;
  } vec_t;

  vec_t tbl [21];

  initial begin
    //          rst   req   busy  frc   idle  en    ack   all_off
    tbl[0]  = '{1'b0, 4'h0, 4'h0, 4'h0, 8'd2, 4'h0, 4'h0, 1'b1};
    tbl[1]  = '{1'b1, 4'h1, 4'h0, 4'h0, 8'd2, 4'h1, 4'h0, 1'b1};
    tbl[2]  = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h1, 4'h0, 1'b0};
    tbl[3]  = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h1, 4'h1, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h1, 4'h1, 1'b0};
    tbl[5]  = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h1, 4'h1, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h0, 4'h0, 1'b1};
    tbl[8]  = '{1'b1, 4'h0, 4'h1, 4'h0, 8'd2, 4'h0, 4'h0, 1'b1};
    tbl[9]  = '{1'b1, 4'h0, 4'h0, 4'h1, 8'd2, 4'h1, 4'h0, 1'b1};
    tbl[10] = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h1, 4'h0, 1'b0};
    tbl[11] = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h1, 4'h1, 1'b0};
    tbl[12] = '{1'b1, 4'h0, 4'h1, 4'h0, 8'd2, 4'h1, 4'h1, 1'b0};
    tbl[13] = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd0, 4'h1, 4'h1, 1'b0};
    tbl[14] = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd0, 4'h1, 4'h1, 1'b0};
    tbl[15] = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h1, 4'h1, 1'b0};
    tbl[16] = '{1'b1, 4'h1, 4'h0, 4'h0, 8'd2, 4'h1, 4'h1, 1'b0};
    tbl[17] = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h1, 4'h1, 1'b0};
    tbl[18] = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h1, 4'h1, 1'b0};
    tbl[19] = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h0, 4'h0, 1'b0};
    tbl[20] = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd2, 4'h0, 4'h0, 1'b1};

    rst_n = 1'b0; tst_en = 1'b0; ch_busy = '0; cfg_force_on = '0;
    ch_req = '1; cfg_idle_cyc = 8'd8;

    // Reset held with every channel requesting.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_clk_en", 32'(ch_clk_en), 32'h0);
      chk("rst_ack",    32'(ch_ack),    32'h0);
      chk("rst_all_off", 32'(all_off),  32'h1);
    end
    rst_n = 1'b1;
    step();
    chk("rel_clk_en", 32'(ch_clk_en), 32'hF);
    chk("rel_ack",    32'(ch_ack),    32'h0);
    chk("rel_all_off", 32'(all_off),  32'h1);
    step();
    chk("rel2_all_off", 32'(all_off), 32'h0);
    chk_model("rel");

    // Vector table, channel 0 only.
    for (int r = 0; r < 21; r++) begin
      rst_n = tbl[r].rst_n; ch_req = tbl[r].req; ch_busy = tbl[r].busy;
      cfg_force_on = tbl[r].frc; cfg_idle_cyc = tbl[r].idle;
      step();
      chk($sformatf("tbl%0d_clk_en", r), 32'(ch_clk_en), 32'(tbl[r].en));
      chk($sformatf("tbl%0d_ack", r),    32'(ch_ack),    32'(tbl[r].ack));
      chk($sformatf("tbl%0d_all_off", r), 32'(all_off),  32'(tbl[r].all_off));
    end

    // Busy activity every few quiet cycles keeps channel 1 alive.
    do_reset();
    cfg_idle_cyc = 8'd4;
    ch_req = 4'h2; step();
    ch_req = 4'h0; step(); step();
    for (int k = 0; k < 8; k++) begin
      ch_busy = 4'h0; step(); step(); step();
      chk_model("busy_loop");
      ch_busy = 4'h2; step();
      chk("busy_hold_ack1", 32'(ch_ack[1]), 32'd1);
    end
    ch_busy = 4'h0;
    for (int k = 0; k < 4; k++) step();
    chk("busy_quiet4_en1", 32'(ch_clk_en[1]), 32'd1);
    step();
    chk("busy_quiet5_en1", 32'(ch_clk_en[1]), 32'd0);
    chk("busy_quiet5_ack1", 32'(ch_ack[1]), 32'd0);
    chk_model("busy_end");

    // Force-on on channel 2, disabled timeout on channel 3.
    do_reset();
    cfg_idle_cyc = 8'd0; cfg_force_on = 4'h4; ch_req = 4'h8;
    step();
    ch_req = 4'h0;
    for (int k = 0; k < 30; k++) step();
    chk("frc_ack32", 32'(ch_ack[3:2]), 32'h3);
    chk_model("frc");
    cfg_idle_cyc = 8'd3;
    for (int k = 0; k < 5; k++) step();
    chk("frc_ack2_kept", 32'(ch_ack[2]), 32'd1);
    chk("idle_ack3_off", 32'(ch_ack[3]), 32'd0);
    chk_model("frc_end");

    // Timeout lowered live below the running count.
    do_reset();
    cfg_idle_cyc = 8'd200;
    wake_ch0_to_idle();
    for (int k = 0; k < 10; k++) step();
    chk("lower_before_en0", 32'(ch_clk_en[0]), 32'd1);
    cfg_idle_cyc = 8'd5;
    step();
    chk("lower_after_en0", 32'(ch_clk_en[0]), 32'd0);
    chk("lower_after_ack0", 32'(ch_ack[0]), 32'd0);
    chk_model("lower");

    // Longest timeout reaches the top of the counter range.
    do_reset();
    cfg_idle_cyc = 8'd255;
    wake_ch0_to_idle();
    for (int k = 0; k < 254; k++) step();
    chk("sat_before_en0", 32'(ch_clk_en[0]), 32'd1);
    step();
    chk("sat_after_en0", 32'(ch_clk_en[0]), 32'd0);
    chk_model("sat");

    // Test mode with everything off, then a normal gated clock edge.
    do_reset();
    tst_en = 1'b1;
    step();
    chk("tm_gclk_high", 32'(gated_clk), 32'hF);
    chk("tm_ack", 32'(ch_ack), 32'h0);
    chk("tm_all_off", 32'(all_off), 32'h1);
    @(negedge clk); #1;
    chk("tm_gclk_low", 32'(gated_clk), 32'h0);
    tst_en = 1'b0;
    step();
    chk("tm_off_gclk", 32'(gated_clk), 32'h0);
    ch_req = 4'h1; step();
    chk("gclk_edge_t", 32'(gated_clk[0]), 32'd0);
    ch_req = 4'h0; step();
    chk("gclk_edge_t1", 32'(gated_clk[0]), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    cfg_idle_cyc = 8'd3;
    for (int k = 0; k < 600; k++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      tst_en       = 1'($urandom);
      ch_req       = 4'($urandom) & 4'($urandom) & 4'($urandom);
      ch_busy      = 4'($urandom) & 4'($urandom);
      cfg_force_on = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 7) == 0)
        cfg_idle_cyc = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      step();
      chk_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
